// File: rtl/periph_bus_master_if.sv
// Core request/response and word-indexed peripheral bus signals for periph_bus_master.
// master = the initiator block, slave = core + peripheral side.
interface periph_bus_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] bus_addr;
   logic        bus_wr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;

   modport master (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, bus_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, bus_addr, bus_wr, bus_wdata
   );

   modport slave (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, bus_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, bus_addr, bus_wr, bus_wdata
   );
endinterface

// File: rtl/periph_bus_master.sv
// Single-outstanding load/store initiator for the word-indexed peripheral bus; sub-word stores are read-modify-write.
// Define MISALIGN_TRAP_EN to reject misaligned half/word accesses with rsp_err instead of issuing a bus cycle.
module periph_bus_master #(
   parameter int BUS_ADDR_W = 22,
   parameter int RD_WAIT    = 0
) (
   input logic                 clk,
   input logic                 rst,
   periph_bus_master_if.master bif
);
   typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_e;

   localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT);

   state_e      state_q, state_d;
   logic        req_ready_q, req_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic        bus_wr_q, bus_wr_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [3:0]  wait_q, wait_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] wdata_q, wdata_d;
   logic        mis;

   function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] sz,
                                                input logic uns, input logic [1:0] off);
      logic [31:0] sh;
      sh = w;
      lane_extract = w;
      if (sz == 2'd0) begin
         sh = w >> {off, 3'b000};
         lane_extract = {{24{sh[7] & ~uns}}, sh[7:0]};
      end else if (sz == 2'd1) begin
         sh = w >> {off[1], 4'b0000};
         lane_extract = {{16{sh[15] & ~uns}}, sh[15:0]};
      end
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [1:0] off);
      logic [4:0]  sh;
      logic [31:0] mask;
      sh   = (sz == 2'd0) ? {off, 3'b000} : {off[1], 4'b0000};
      mask = ((sz == 2'd0) ? 32'h0000_00ff : 32'h0000_ffff) << sh;
      lane_merge = (w & ~mask) | ((d << sh) & mask);
   endfunction

`ifdef MISALIGN_TRAP_EN
   logic err_q, err_d;
   logic rsp_err_q, rsp_err_d;
   assign mis = ((bif.req_size == 2'd1) && bif.req_addr[0]) ||
                (bif.req_size[1] && (bif.req_addr[1:0] != 2'b00));
   assign bif.rsp_err = rsp_err_q;
`else
   assign mis = 1'b0;
   assign bif.rsp_err = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      bus_addr_d  = bus_addr_q;
      bus_wr_d    = 1'b0;
      bus_wdata_d = bus_wdata_q;
      wait_d      = wait_q;
      we_d        = we_q;
      size_d      = size_q;
      uns_d       = uns_q;
      off_d       = off_q;
      wdata_d     = wdata_q;
`ifdef MISALIGN_TRAP_EN
      err_d       = err_q;
      rsp_err_d   = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (bif.req_valid && req_ready_q) begin
               we_d        = bif.req_we;
               size_d      = (bif.req_size == 2'd3) ? 2'd2 : bif.req_size;
               uns_d       = bif.req_unsigned;
               off_d       = bif.req_addr[1:0];
               wdata_d     = bif.req_wdata;
               wait_d      = 4'd0;
               rsp_rdata_d = 32'd0;
`ifdef MISALIGN_TRAP_EN
               err_d       = mis;
`endif
               if (mis) begin
                  state_d = RSP;
               end else begin
                  bus_addr_d = {{(32-BUS_ADDR_W){1'b0}}, bif.req_addr[BUS_ADDR_W+1:2]};
                  if (bif.req_we && (size_d == 2'd2)) begin
                     state_d     = WR;
                     bus_wr_d    = 1'b1;
                     bus_wdata_d = bif.req_wdata;
                  end else begin
                     state_d = RD;
                  end
               end
            end
         end
         RD: begin
            if (wait_q == WAIT_LAST) begin
               if (we_q) begin
                  // The merged word is committed only here, so an aborted RMW never reaches the bus.
                  bus_wdata_d = lane_merge(bif.bus_rdata, wdata_q, size_q, off_q);
                  bus_wr_d    = 1'b1;
                  state_d     = WR;
               end else begin
                  rsp_rdata_d = lane_extract(bif.bus_rdata, size_q, uns_q, off_q);
                  state_d     = RSP;
               end
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         WR: state_d = RSP;
         RSP: begin
            rsp_valid_d = 1'b1;
`ifdef MISALIGN_TRAP_EN
            rsp_err_d   = err_q;
`endif
            state_d     = IDLE;
         end
      endcase
      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         bus_addr_q  <= 32'd0;
         bus_wr_q    <= 1'b0;
         bus_wdata_q <= 32'd0;
         wait_q      <= 4'd0;
         we_q        <= 1'b0;
         size_q      <= 2'd0;
         uns_q       <= 1'b0;
         off_q       <= 2'd0;
         wdata_q     <= 32'd0;
`ifdef MISALIGN_TRAP_EN
         err_q       <= 1'b0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         bus_addr_q  <= bus_addr_d;
         bus_wr_q    <= bus_wr_d;
         bus_wdata_q <= bus_wdata_d;
         wait_q      <= wait_d;
         we_q        <= we_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         off_q       <= off_d;
         wdata_q     <= wdata_d;
`ifdef MISALIGN_TRAP_EN
         err_q       <= err_d;
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

   assign bif.req_ready = req_ready_q;
   assign bif.rsp_valid = rsp_valid_q;
   assign bif.rsp_rdata = rsp_rdata_q;
   assign bif.bus_addr  = bus_addr_q;
   assign bif.bus_wr    = bus_wr_q;
   assign bif.bus_wdata = bus_wdata_q;
endmodule

// File: tb/tb_periph_bus_master.sv
// Bench for periph_bus_master: peripheral memory model plus a byte-level reference model of loads/stores.
module tb_periph_bus_master;
   localparam int W = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   periph_bus_master_if bif();
   periph_bus_master #(.BUS_ADDR_W(22), .RD_WAIT(W)) dut (.clk(clk), .rst(rst), .bif(bif));

   logic [31:0] mem [64];
   logic [31:0] shadow [64];
   logic        init_en = 1'b1;
   int          wr_cnt = 0;
   int          cyc_ctr = 0;
   int          acc_n = 0;
   int          acc_cyc_last = 0;
   int          n_pass = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   function automatic logic [31:0] init_word(input int i);
      return (32'(i) * 32'h9E37_79B9) ^ 32'h0F0F_1234;
   endfunction

   assign bif.bus_rdata = mem[bif.bus_addr[5:0]];

   always @(posedge clk) begin
      cyc_ctr <= cyc_ctr + 1;
      if (bif.req_valid && bif.req_ready) begin
         acc_n        <= acc_n + 1;
         acc_cyc_last <= cyc_ctr;
      end
      if (init_en) begin
         for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      end else if (bif.bus_wr) begin
         mem[bif.bus_addr[5:0]] <= bif.bus_wdata;
         wr_cnt <= wr_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: byte lanes selected by arithmetic on the byte address.
   function automatic int nbytes(input int sz);
      return (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
   endfunction
   function automatic int lane_off(input int sz, input int a);
      return (sz == 0) ? a % 4 : (sz == 1) ? ((a % 4) / 2) * 2 : 0;
   endfunction
   function automatic logic [31:0] m_load(input logic [31:0] w, input int sz, input bit uns, input int a);
      longint v;
      int     nb;
      nb = nbytes(sz);
      v  = (longint'(w) >> (8 * lane_off(sz, a))) % (longint'(1) << (8 * nb));
      if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
      return v[31:0];
   endfunction
   function automatic logic [31:0] m_store(input logic [31:0] old, input int sz, input int a, input logic [31:0] d);
      logic [31:0] r;
      int          off;
      r   = old;
      off = lane_off(sz, a);
      for (int i = 0; i < nbytes(sz); i++) r[8*(off+i) +: 8] = d[8*i +: 8];
      return r;
   endfunction
   function automatic bit m_mis(input int sz, input int a);
`ifdef MISALIGN_TRAP_EN
      return (sz == 1 && (a % 2) != 0) || (sz >= 2 && (a % 4) != 0);
`else
      return 1'b0;
`endif
   endfunction

   task automatic drive(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] addr, input logic [31:0] wdata);
      bif.req_valid    = 1'b1;
      bif.req_we       = we;
      bif.req_size     = sz;
      bif.req_unsigned = uns;
      bif.req_addr     = addr;
      bif.req_wdata    = wdata;
   endtask

   // Called at a negedge with the request driven; returns just after the accepting edge.
   task automatic wait_accept(input string tag);
      bit got;
      got = 1'b0;
      for (int k = 0; k < 64; k++) begin
         if (bif.req_ready) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      check({tag, "/accept"}, 32'(got), 32'd1);
   endtask

   task automatic xact(input string tag, input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
      int          idx, exp_lat, cyc, wr0, szi, ai;
      bit          mis, got;
      logic [31:0] exp_rd, exp_idx, prev_addr;
      idx     = int'(addr[7:2]);
      szi     = int'(sz);
      ai      = int'(addr[1:0]);
      mis     = m_mis(szi, ai);
      exp_rd  = (we || mis) ? 32'd0 : m_load(shadow[idx], szi, uns, ai);
      exp_lat = mis ? 1 : (we && szi < 2) ? 3 + W : we ? 2 : 2 + W;
      @(negedge clk);
      prev_addr = bif.bus_addr;
      exp_idx   = mis ? prev_addr : {10'd0, addr[23:2]};
      drive(we, sz, uns, addr, wdata);
      wait_accept(tag);
      bif.req_valid = 1'b0;
      wr0 = wr_cnt;
      check({tag, "/busy"}, 32'(bif.req_ready), 32'd0);
      cyc = 0;
      got = 1'b0;
      for (int k = 0; k < 64 && !got; k++) begin
         @(posedge clk);
         #1;
         cyc++;
         got = bif.rsp_valid;
      end
      check({tag, "/latency"}, got ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_lat));
      check({tag, "/rdata"}, bif.rsp_rdata, exp_rd);
      check({tag, "/err"}, 32'(bif.rsp_err), 32'(mis));
      check({tag, "/bus_addr"}, bif.bus_addr, exp_idx);
      check({tag, "/writes"}, 32'(wr_cnt - wr0), (we && !mis) ? 32'd1 : 32'd0);
      if (we && !mis) begin
         shadow[idx] = m_store(shadow[idx], szi, ai, wdata);
         check({tag, "/mem"}, mem[idx], shadow[idx]);
      end
      @(posedge clk);
      #1;
      check({tag, "/pulse"}, 32'(bif.rsp_valid), 32'd0);
   endtask

   // Sub-word store aborted by reset, either while reading or during the write cycle.
   task automatic abort_test(input string tag, input bit in_wr, input logic [31:0] addr, input logic [31:0] wdata);
      int idx, wr0;
      bit seen;
      idx = int'(addr[7:2]);
      @(negedge clk);
      drive(1'b1, 2'd0, 1'b0, addr, wdata);
      wait_accept(tag);
      bif.req_valid = 1'b0;
      wr0 = wr_cnt;
      if (in_wr) begin
         for (int k = 0; k < 64; k++) begin
            if (bif.bus_wr) break;
            @(posedge clk);
            #1;
         end
         shadow[idx] = m_store(shadow[idx], 0, int'(addr[1:0]), wdata);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "/bus_wr"}, 32'(bif.bus_wr), 32'd0);
      check({tag, "/writes"}, 32'(wr_cnt - wr0), in_wr ? 32'd1 : 32'd0);
      seen = bif.rsp_valid;
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         seen = seen | bif.rsp_valid;
      end
      check({tag, "/no_rsp"}, 32'(seen), 32'd0);
      check({tag, "/mem"}, mem[idx], shadow[idx]);
      check({tag, "/ready"}, 32'(bif.req_ready), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n0, a1, a2, r1, r2;
      logic [31:0] rd1, rd2, exp_w;
      bit          got;
      bif.req_valid = 1'b0;
      bif.req_we = 1'b0;
      bif.req_size = 2'd0;
      bif.req_unsigned = 1'b0;
      bif.req_addr = 32'd0;
      bif.req_wdata = 32'd0;
      for (int i = 0; i < 64; i++) shadow[i] = init_word(i);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst/bus_addr", bif.bus_addr, 32'd0);
      check("rst/bus_wdata", bif.bus_wdata, 32'd0);
      check("rst/rsp_rdata", bif.rsp_rdata, 32'd0);
      check("rst/bus_wr", 32'(bif.bus_wr), 32'd0);
      check("rst/rsp_valid", 32'(bif.rsp_valid), 32'd0);
      check("rst/rsp_err", 32'(bif.rsp_err), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      init_en = 1'b0;
      @(posedge clk);
      #1;
      check("rst/ready", 32'(bif.req_ready), 32'd1);
      check("rst/no_wr", 32'(wr_cnt), 32'd0);

      // Directed cases
      xact("wst", 1'b1, 2'd2, 1'b0, 32'h0000_0004, 32'hDEAD_BEEF);
      check("wst/const", mem[1], 32'hDEAD_BEEF);
      xact("w0", 1'b1, 2'd2, 1'b0, 32'h0000_0000, 32'h80FF_0000);
      xact("lb_s", 1'b0, 2'd0, 1'b0, 32'h0000_0003, 32'd0);
      check("lb_s/const", bif.rsp_rdata, 32'hFFFF_FF80);
      xact("lb_u", 1'b0, 2'd0, 1'b1, 32'h0000_0003, 32'd0);
      check("lb_u/const", bif.rsp_rdata, 32'h0000_0080);
      xact("w8", 1'b1, 2'd2, 1'b0, 32'h0000_0008, 32'h1122_3344);
      xact("sb", 1'b1, 2'd0, 1'b0, 32'h0000_0009, 32'h0000_00AB);
      check("sb/const", mem[2], 32'h1122_AB44);
      xact("sh", 1'b1, 2'd1, 1'b0, 32'h0000_000A, 32'h0000_5566);
      xact("lh_hi", 1'b0, 2'd1, 1'b0, 32'h0000_0002, 32'd0);
      xact("lh_mis", 1'b0, 2'd1, 1'b0, 32'h0000_0001, 32'd0);
      xact("lw_mis", 1'b0, 2'd3, 1'b0, 32'h0000_0006, 32'd0);
      xact("wrap", 1'b0, 2'd2, 1'b0, 32'hFFC0_0010, 32'd0);

      // Back-to-back: request held high across two accepts
      n0 = acc_n;
      a1 = -1; a2 = -1; r1 = -1; r2 = -1;
      rd1 = 32'd0; rd2 = 32'd0;
      exp_w = shadow[8];
      @(negedge clk);
      drive(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'd0);
      for (int k = 0; k < 60; k++) begin
         @(posedge clk);
         #1;
         if (acc_n >= n0 + 1 && a1 < 0) a1 = acc_cyc_last;
         if (bif.rsp_valid && r1 < 0) begin
            r1  = cyc_ctr - 1;
            rd1 = bif.rsp_rdata;
         end
         if (acc_n >= n0 + 2) begin
            a2 = acc_cyc_last;
            bif.req_valid = 1'b0;
            break;
         end
      end
      got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
         @(posedge clk);
         #1;
         got = bif.rsp_valid;
         if (got) begin
            r2  = cyc_ctr - 1;
            rd2 = bif.rsp_rdata;
         end
      end
      check("b2b/lat1", 32'(r1 - a1), 32'(2 + W));
      check("b2b/gap", 32'(a2 - a1), 32'(2 + W + 1));
      check("b2b/lat2", 32'(r2 - a2), 32'(2 + W));
      check("b2b/rd1", rd1, exp_w);
      check("b2b/rd2", rd2, exp_w);

      // Randomized traffic against the reference model
      for (int t = 0; t < 40; t++) begin
         logic [31:0] ra;
         ra = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 255));
         xact("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ra, $urandom);
      end

      // Reset aborts
      abort_test("abort_rd", 1'b0, 32'h0000_0031, 32'h0000_00C3);
      abort_test("abort_wr", 1'b1, 32'h0000_0036, 32'h0000_005A);
      xact("post", 1'b0, 2'd2, 1'b0, 32'h0000_0034, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/periph_bus_master.md
Name: periph_bus_master

Overview:
- CPU-side initiator for the memory-mapped peripheral bus.
- Accepts one load/store request at a time from the core (byte/half/word, byte-addressed) and converts it to word-indexed bus cycles.
- Drives bus_addr/bus_wr/bus_wdata and samples bus_rdata.
- Peripheral registers accept only full-word writes, so sub-word stores are done as read-modify-write.

Parameters:
- BUS_ADDR_W, 22, width of word index driven on bus_addr; bus_addr bits above it are 0.
- RD_WAIT, 0, extra cycles held in RD before bus_rdata is sampled (0..15).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-low reset
- req_valid  input  1  core request present
- req_ready  output  1  block can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = half, 2 = word; 3 treated as word
- req_unsigned  input  1  zero-extend load result (LBU/LHU)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- rsp_valid  output  1  one-cycle pulse: access complete
- rsp_rdata  output  32  load result, extended; 0 for stores
- rsp_err  output  1  misaligned access flag, valid with rsp_valid (MISALIGN_TRAP_EN only, else tied 0)
- bus_addr  output  32  word index = req_addr[BUS_ADDR_W+1:2], zero-padded
- bus_wr  output  1  write strobe; peripheral writes on the clk edge where bus_wr=1
- bus_wdata  output  32  full-word write data
- bus_rdata  input  32  combinational read data for bus_addr

Behaviour:
Reset:
- rst low at a clk edge: state=IDLE.
- bus_addr, bus_wdata, rsp_rdata = 0; bus_wr, rsp_valid, rsp_err = 0.
- req_ready = 1 from the first cycle after rst returns high.

General:
- All outputs are registered.
- Request latched on req_valid & req_ready; req_ready = 1 only in IDLE.

States:
- IDLE
  - On accept, latch request and set bus_addr.
  - Load or sub-word store -> RD.
  - Word store -> WR, with bus_wdata = req_wdata and bus_wr = 1.
- RD
  - bus_wr = 0; wait counter counts RD_WAIT cycles, then bus_rdata is sampled.
  - Load: sampled word -> lane extract -> rsp_rdata; go to RSP.
  - Sub-word store: merge req_wdata into the addressed lane of the sampled word.
    - Byte: lane = addr[1:0].
    - Half: lane = addr[1].
  - Sub-word store then -> WR with bus_wr = 1 and bus_wdata = merged word.
- WR
  - bus_wr high exactly one cycle; bus_addr stable; -> RSP.
- RSP
  - rsp_valid = 1 for one cycle, then rsp_valid = 0 and bus_wr = 0; -> IDLE.
  - Earliest next accept is the cycle after RSP.

Latency (accept edge to rsp_valid):
- Load: 2 + RD_WAIT cycles.
- Word store: 2 cycles.
- Sub-word store: 3 + RD_WAIT cycles.

Lane extraction for loads:
- Byte: bits [8*a+7 : 8*a], a = addr[1:0].
- Half: bits [16*h+15 : 16*h], h = addr[1].
- Sign-extend from the top bit unless req_unsigned; word loads pass through.

Boundary conditions:
- req_valid while busy: ignored (req_ready = 0); the core must hold the request.
- Address beyond BUS_ADDR_W: upper bits dropped; the wrapped index is used.
- Reset in any state: the access is aborted, no rsp_valid is issued, and bus_wr deasserts on the reset edge.
- A partially merged RMW is never written.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - Half with addr[0] = 1, or word with addr[1:0] != 0, goes IDLE -> RSP directly.
  - No bus cycle is issued (bus_wr stays 0, bus_addr unchanged).
  - rsp_err = 1, rsp_rdata = 0; rsp_err = 0 on all other responses.
- Undefined:
  - Half ignores addr[0]; word ignores addr[1:0].
  - rsp_err is constant 0.

Test Plan:
- Reset, then release rst -> all outputs 0, req_ready=1 next cycle, bus_wr never pulsed.
- Word store, addr=0x0000_0004, wdata=0xDEAD_BEEF -> bus_addr=1, one bus_wr pulse with bus_wdata=0xDEADBEEF, rsp_valid 2 cycles after accept, rsp_rdata=0.
- Signed byte load, addr=0x3, bus_rdata=0x80FF_0000 -> rsp_rdata=0xFFFF_FF80; same with req_unsigned=1 -> 0x0000_0080.
- Byte store, addr=0x1, wdata=0xAB, existing word 0x1122_3344 -> exactly one RD then one WR, bus_wdata=0x1122_AB44, rsp_valid at 3+RD_WAIT.
- RD_WAIT=3, word load -> bus_rdata sampled after 4 RD cycles, rsp_valid 5 cycles after accept; back-to-back req_valid held -> second accept only after rsp_valid.
- rst low during WR of sub-word store -> no rsp_valid, bus_wr=0 after edge. With MISALIGN_TRAP_EN, half load addr=0x1 -> rsp_err=1, no bus activity.
